// File: rtl/scope_trigger_capture.sv
// Oscilloscope-style trigger and capture block.
// Watches a selected channel for a signed level crossing and records a
// selected channel into a DEPTH-sample ring buffer. The buffer holds pretrig
// samples before the trigger sample and the rest after it. After capture,
// a registered read port returns the samples in time order (index 0 = oldest).
module scope_trigger_capture #(
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] ch_a,
  input  logic signed [DATA_W-1:0] ch_b,
  input  logic signed [DATA_W-1:0] ch_c,
  input  logic signed [DATA_W-1:0] ch_d,
  input  logic [1:0]               trig_src,
  input  logic [1:0]               cap_sel,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     trig_edge,
  input  logic [AW-1:0]            pretrig,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t state;

  // Settings captured on an accepted arm
  logic [1:0]               trig_src_q;
  logic [1:0]               cap_sel_q;
  logic signed [DATA_W-1:0] trig_level_q;
  logic                     trig_edge_q;
  logic [AW-1:0]            pretrig_q;

  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            start_ptr;
  logic [AW-1:0]            cnt;
  logic signed [DATA_W-1:0] prev;
  logic                     prev_valid;

  logic signed [DATA_W-1:0] mem [DEPTH];

  logic signed [DATA_W-1:0] cur_trig;
  logic signed [DATA_W-1:0] cur_cap;
  logic                     capturing;
  logic                     arm_ok;
  logic                     rise_hit;
  logic                     fall_hit;
  logic                     trig_hit;
  logic [AW-1:0]            post_last;
  logic [AW-1:0]            rd_idx;

  // Four-way channel select shared by the trigger and capture paths
  function automatic logic signed [DATA_W-1:0] sel_chan(
    input logic [1:0]               sel,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] c,
    input logic signed [DATA_W-1:0] d
  );
    logic signed [DATA_W-1:0] r;
    case (sel)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = c;
      default: r = d;
    endcase
    return r;
  endfunction

  // Trigger detection, write enable and the POST length
  always_comb begin
    cur_trig  = sel_chan(trig_src_q, ch_a, ch_b, ch_c, ch_d);
    cur_cap   = sel_chan(cap_sel_q, ch_a, ch_b, ch_c, ch_d);
    capturing = (state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_POST);
    arm_ok    = arm && ((state == S_IDLE) || (state == S_DONE));
    rise_hit  = prev_valid && (prev < trig_level_q) && (cur_trig >= trig_level_q);
    fall_hit  = prev_valid && (prev > trig_level_q) && (cur_trig <= trig_level_q);
    trig_hit  = force_trig || (trig_edge_q ? fall_hit : rise_hit);
    // DEPTH-1-pretrig samples follow the trigger; ~pretrig equals that count
    post_last = ~pretrig_q - AW'(1);
    rd_idx    = start_ptr + rd_addr;
  end

  // Latch capture settings when an arm is accepted
  always_ff @(posedge clk) begin
    if (arm_ok) begin
      trig_src_q   <= trig_src;
      cap_sel_q    <= cap_sel;
      trig_level_q <= trig_level;
      trig_edge_q  <= trig_edge;
      pretrig_q    <= pretrig;
    end
  end

  // Capture sequencer: state, pointers, counters, prev-sample tracking and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      wr_ptr     <= '0;
      start_ptr  <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (capturing) begin
        wr_ptr     <= wr_ptr + AW'(1);
        prev       <= cur_trig;
        prev_valid <= 1'b1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            done       <= 1'b0;
            triggered  <= 1'b0;
            prev_valid <= 1'b0;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= (pretrig == '0) ? S_WAIT_TRIG : S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (cnt == pretrig_q - AW'(1)) begin
            cnt   <= '0;
            state <= S_WAIT_TRIG;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_WAIT_TRIG: begin
          if (trig_hit) begin
            start_ptr <= wr_ptr - pretrig_q;
            triggered <= 1'b1;
            cnt       <= '0;
            if (pretrig_q == '1) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (cnt == post_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (capturing) begin
      mem[wr_ptr] <= cur_cap;
    end
  end

  // Registered read port, rotated so index 0 is the oldest captured sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with DEPTH=16.
module tb_scope_trigger_capture;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic               clk;
  logic               reset;
  logic signed [15:0] ch_a, ch_b, ch_c, ch_d;
  logic [1:0]         trig_src, cap_sel;
  logic signed [15:0] trig_level;
  logic               trig_edge;
  logic [AW-1:0]      pretrig;
  logic               arm, force_trig;
  logic [AW-1:0]      rd_addr;
  logic signed [15:0] rd_data;
  logic               busy, triggered, done;

  int n_checks = 0;
  int n_fail   = 0;
  int s        = 0;

  scope_trigger_capture #(.DEPTH(DEPTH), .AW(AW), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d),
    .trig_src(trig_src), .cap_sel(cap_sel), .trig_level(trig_level),
    .trig_edge(trig_edge), .pretrig(pretrig), .arm(arm), .force_trig(force_trig),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .triggered(triggered), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic set_s(input int v);
    s    = v;
    ch_a = 16'(v);
    ch_b = 16'(-v);
    ch_c = 16'(3 * v);
    ch_d = 16'h7FFF;
  endtask

  // One clock; inputs advance the ramp just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    set_s(s + 1);
  endtask

  task automatic setup(input logic [1:0] src, input logic [1:0] cap, input int lvl,
                       input logic edg, input int pre);
    trig_src   = src;
    cap_sel    = cap;
    trig_level = 16'(lvl);
    trig_edge  = edg;
    pretrig    = AW'(pre);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int n;
    n = 0;
    while (!triggered && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, triggered, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, n, exp_cycles);
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp);
    rd_addr = AW'(addr);
    tick();
    check_eq(tag, rd_data, exp);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; force_trig = 1'b0; rd_addr = '0;
    setup(2'd0, 2'd0, 100, 1'b0, 4);
    set_s(0);
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_trig", triggered, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd", rd_data, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Ramp on a, rising through 100, pretrig 4; stray arm + level change mid-capture
    setup(2'd0, 2'd0, 100, 1'b0, 4);
    set_s(0);
    do_arm();
    check_eq("t1_busy", busy, 1);
    for (int i = 0; i < 49; i++) tick();
    check_eq("t1_wait_busy", busy, 1);
    check_eq("t1_wait_trig", triggered, 0);
    trig_level = 16'sd70;
    do_arm();
    wait_trig("t1_trig", 300);
    check_eq("t1_trig_sample", s, 101);
    wait_done("t1_done_lat", 11);
    check_eq("t1_busy_done", busy, 0);
    for (int i = 0; i < DEPTH; i++) read_chk("t1_rd", i, 96 + i);
    read_chk("t1_rd4", 4, 100);

    // Falling on negative ramp b, armed from DONE with new settings
    setup(2'd1, 2'd1, -50, 1'b1, 8);
    set_s(0);
    do_arm();
    check_eq("t2_done_clr", done, 0);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_trig_clr", triggered, 0);
    wait_trig("t2_trig", 300);
    wait_done("t2_done_lat", 7);
    read_chk("t2_rd8", 8, -50);
    read_chk("t2_rd0", 0, -42);
    read_chk("t2_rd15", 15, -57);

    // Constant d never crosses; force_trig ends the wait
    setup(2'd3, 2'd3, 0, 1'b0, 2);
    set_s(0);
    do_arm();
    for (int i = 0; i < 1000; i++) tick();
    check_eq("t3_busy", busy, 1);
    check_eq("t3_no_trig", triggered, 0);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    check_eq("t3_force", triggered, 1);
    wait_done("t3_done_lat", 13);
    for (int i = 0; i < DEPTH; i++) read_chk("t3_rd", i, 32767);

    // pretrig 0 with level ahead of the ramp
    setup(2'd0, 2'd0, 20, 1'b0, 0);
    set_s(0);
    do_arm();
    wait_trig("t4_trig", 100);
    wait_done("t4_done_lat", 15);
    read_chk("t4_rd0", 0, 20);
    read_chk("t4_rd15", 15, 35);

    // pretrig 0 with ramp already above level: first sample has no prev
    setup(2'd0, 2'd0, 100, 1'b0, 0);
    set_s(200);
    do_arm();
    for (int i = 0; i < 50; i++) tick();
    check_eq("t5_no_trig", triggered, 0);
    check_eq("t5_busy", busy, 1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    wait_done("t5_done_lat", 15);

    // pretrig DEPTH-1: done together with triggered
    setup(2'd0, 2'd0, 100, 1'b0, 15);
    set_s(0);
    do_arm();
    wait_trig("t6_trig", 300);
    check_eq("t6_done_now", done, 1);
    check_eq("t6_busy", busy, 0);
    read_chk("t6_rd15", 15, 100);
    read_chk("t6_rd0", 0, 85);

    // Reset in the middle of POST, then a clean recapture
    setup(2'd0, 2'd0, 30, 1'b0, 4);
    set_s(0);
    do_arm();
    wait_trig("t7_trig", 300);
    tick(); tick(); tick();
    check_eq("t7_post_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_eq("t7_rst_busy", busy, 0);
    check_eq("t7_rst_trig", triggered, 0);
    check_eq("t7_rst_done", done, 0);
    check_eq("t7_rst_rd", rd_data, 0);
    tick();
    check_eq("t7_rst_hold", busy, 0);
    reset = 1'b1;
    tick();
    setup(2'd0, 2'd0, 60, 1'b0, 4);
    set_s(0);
    do_arm();
    wait_trig("t7_retrig", 300);
    wait_done("t7_done_lat", 11);
    read_chk("t7_rd0", 0, 56);
    read_chk("t7_rd4", 4, 60);
    read_chk("t7_rd15", 15, 71);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Downstream consumer of the four signed 16-bit test/input channels (a, b, c, d).
- Watches one selected channel for a level-crossing trigger and records one selected channel into a DEPTH-sample ring buffer, split into pre-trigger and post-trigger samples.
- Presents the finished capture through a synchronous read port in time order, for the oscilloscope readout path.

Parameters:
- DEPTH, 256: capture length in samples; power of two, at least 4.
- AW, 8: address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_a, ch_b, ch_c, ch_d  in  16 each (signed)  sample inputs, one new sample per clk.
- trig_src  in  2  trigger channel select: 0=a, 1=b, 2=c, 3=d.
- cap_sel  in  2  recorded channel select, same encoding.
- trig_level  in  16 (signed)  trigger threshold.
- trig_edge  in  1  0=rising, 1=falling.
- pretrig  in  AW  number of samples kept before the trigger sample.
- arm  in  1  single-cycle start pulse.
- force_trig  in  1  software trigger.
- rd_addr  in  AW  logical read index; 0 is the oldest sample.
- rd_data  out  16 (signed)  registered read data.
- busy  out  1  high in PREFILL, WAIT_TRIG and POST.
- triggered  out  1  trigger has occurred in this capture.
- done  out  1  capture complete; buffer is stable.

Behaviour:
- Reset (reset=0): the following take effect immediately.
  - State goes to IDLE.
  - busy, triggered, done, rd_data = 0.
  - wr_ptr, counters, prev-sample register and prev_valid are cleared.
  - Buffer RAM contents are not cleared.
- Settings latch: trig_src, cap_sel, trig_level, trig_edge and pretrig are latched on an accepted arm. Later changes have no effect until the next arm.
- arm handling:
  - Accepted only in IDLE or DONE.
  - Ignored while busy.
  - On accept: done and triggered clear, and prev_valid clears.
  - Next state is PREFILL, or WAIT_TRIG if pretrig=0.
- Sample write (PREFILL, WAIT_TRIG, POST): every clk, the selected cap channel is written to RAM[wr_ptr] and wr_ptr increments modulo DEPTH.
- Prev-sample register:
  - Every clk in these states, the trig channel value is registered as prev and prev_valid is set.
  - prev is not updated in IDLE or DONE.
- PREFILL:
  - Counts written samples.
  - After pretrig samples have been written, moves to WAIT_TRIG.
  - Trigger conditions are ignored, but prev is still tracked.
- Trigger condition (evaluated in WAIT_TRIG on the current input vs prev; signed compare):
  - Rising: prev_valid and prev < trig_level and cur >= trig_level.
  - Falling: prev_valid and prev > trig_level and cur <= trig_level.
  - force_trig=1 triggers unconditionally.
- On trigger:
  - The current sample is the trigger sample. It is written at trig_ptr = wr_ptr.
  - start_ptr = trig_ptr - pretrig (mod DEPTH) is latched.
  - triggered goes high on the following cycle.
  - Next state is POST, or DONE directly if pretrig = DEPTH-1.
- POST:
  - Writes DEPTH-pretrig-1 further samples, then enters DONE.
  - done goes high the cycle after the last write; busy falls in the same cycle.
- Capture contents: exactly DEPTH samples form the capture, pretrig of them before the trigger sample. Logical index pretrig holds the trigger sample.
- Read port:
  - rd_data = RAM[(start_ptr + rd_addr) mod DEPTH], registered, 1-cycle latency.
  - Valid in DONE.
  - In other states rd_data returns RAM contents that carry no defined meaning.
- Simultaneous arm with reset: reset wins.
- Simultaneous force_trig and level trigger: treated as a single trigger.

Test Plan:
- DEPTH=16, trig_src=a, cap_sel=a, ch_a=ramp 0,1,2…, rising, level=100, pretrig=4, arm → trigger on sample 100 (prev 99); done asserts 11 clk after trigger; rd_addr 0..15 → 96..111; rd_addr 4 → 100.
- Same DEPTH, ch_b=-ramp, trig_src=b, cap_sel=b, falling, level=-50, pretrig=8 → rd_addr 8 = -50, rd_addr 0 = -42, rd_addr 15 = -57.
- ch_d constant 0x7FFF, level=0, rising, pretrig=2 → stays WAIT_TRIG for 1000 clk (busy=1, triggered=0); pulse force_trig → triggered next cycle; done after 13 further clk; all read data = 0x7FFF.
- Boundaries on the ramp input:
  - pretrig=0: a ramp already above level at arm never triggers until it crosses again, because the first sample has no prev; with level ahead of the ramp, trigger sample at rd_addr 0.
  - pretrig=15: done the cycle after trigger; trigger sample at rd_addr 15.
- Drop reset low mid-POST → busy, triggered, done and rd_data = 0 immediately. Re-arm → full capture completes correctly.
- Pulse arm during WAIT_TRIG → ignored, pointers unchanged. Arm in DONE → done clears next cycle; settings changed before this arm take effect.
